// File: rtl/sdram_model_pkg.sv
// Shared types and decode helpers for the SDR SDRAM device model.
package sdram_model_pkg;

   localparam int unsigned NumBanks = 4;
   localparam int unsigned BankW    = 2;
   localparam int unsigned ColW     = 10;
   localparam int unsigned DataW    = 32;
   localparam int unsigned ByteW    = 4;
   localparam int unsigned ClMax    = 3;

   typedef enum logic [2:0] {
      CmdLmr   = 3'b000,
      CmdAref  = 3'b001,
      CmdPre   = 3'b010,
      CmdAct   = 3'b011,
      CmdWrite = 3'b100,
      CmdRead  = 3'b101,
      CmdBst   = 3'b110,
      CmdNop   = 3'b111
   } sdram_cmd_e;

   typedef enum logic {BankIdle, BankOpen} bank_state_e;

   typedef struct packed {
      logic             valid;
      logic [DataW-1:0] data;
      logic [ByteW-1:0] oe;
   } rd_beat_t;

   // Column wrap mask is BL-1, which doubles as the beat count after beat 0.
   function automatic logic [2:0] bl_mask(input logic [1:0] code);
      case (code)
         2'd0:    return 3'd0;
         2'd1:    return 3'd1;
         2'd2:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic lmr_legal(input logic [2:0] cl, input logic [2:0] bl);
      return (cl == 3'd2 || cl == 3'd3) && !bl[2];
   endfunction

   function automatic logic [ColW-1:0] wrap_col(input logic [ColW-1:0] base,
                                                input logic [2:0] idx,
                                                input logic [2:0] mask);
      logic [ColW-1:0] m;
      m = {7'd0, mask};
      return (base & ~m) | ((base + {7'd0, idx}) & m);
   endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency delay line for read beats; entries enter at a CL-dependent slot and drain at slot 0.
module sdram_rd_pipe
   import sdram_model_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     flush,
   input  logic                     ins_valid,
   input  logic [$clog2(DEPTH)-1:0] ins_pos,
   input  logic [DataW-1:0]         ins_data,
   input  logic [ByteW-1:0]         ins_oe,
   output rd_beat_t                 head
);

   rd_beat_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (reset || (en && flush)) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < DEPTH - 1; i++) stage[i] <= stage[i+1];
         stage[DEPTH-1] <= '0;
         if (ins_valid) stage[ins_pos] <= '{valid: 1'b1, data: ins_data, oe: ins_oe};
      end
   end

   assign head = stage[0];

endmodule

// File: rtl/sdram_device_model.sv
// SDR SDRAM responder: command decode, per-bank row state, burst engine and backing store.
// Optional per-bank tRCD/tRP checking is compiled in with SDRAM_TIMING_CHECK_EN.
module sdram_device_model
   import sdram_model_pkg::*;
#(
   parameter int unsigned STORE_AW   = 12,
   parameter int unsigned CL_DEFAULT = 3,
   parameter int unsigned T_RCD      = 3,
   parameter int unsigned T_RP       = 3
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [12:0] sdram_addr,
   input  logic [1:0]  sdram_ba,
   input  logic        sdram_cs_n,
   input  logic        sdram_ras_n,
   input  logic        sdram_cas_n,
   input  logic        sdram_we_n,
   input  logic        sdram_cke,
   input  logic [3:0]  sdram_dqm,
   input  logic [31:0] sdram_dq_in,
   output logic [31:0] sdram_dq_out,
   output logic [3:0]  sdram_dq_oe,
   output logic        cmd_err,
   output logic        timing_err,
   output logic [15:0] refresh_cnt
);

   localparam int unsigned RowW = STORE_AW - 11;

   sdram_cmd_e    cmd;
   bank_state_e   bank_st  [NumBanks];
   logic [RowW-1:0] bank_row [NumBanks];
   logic [1:0]    cl_q;
   logic [2:0]    bl_mask_q;
   logic          burst_wr;
   logic [2:0]    burst_left, burst_idx, burst_mask;
   logic [BankW-1:0] burst_bank;
   logic [RowW-1:0]  burst_row;
   logic [ColW-1:0]  burst_col0;
   logic          rd_issue;
   logic [3:0]    dqm_q;
   logic [31:0]   ram_q;
   logic [31:0]   mem [2**STORE_AW];
   logic          any_open, sel_open, cmd_ok, cmd_bad, rw_ok, pre_hit, burst_stop, flush;
   logic          issue, issue_wr;
   logic [BankW-1:0] issue_bank;
   logic [RowW-1:0]  issue_row;
   logic [ColW-1:0]  issue_col;
   logic [STORE_AW:0]   full_addr;
   logic [STORE_AW-1:0] store_addr;
   logic          ins_pos;
   logic [3:0]    ins_oe;
   rd_beat_t      pipe_head;
   logic          unused_addr;

   assign cmd = sdram_cs_n ? CmdNop : sdram_cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
   assign unused_addr = ^sdram_addr[12:11];

   always_comb begin
      any_open = 1'b0;
      for (int i = 0; i < NumBanks; i++) any_open |= (bank_st[i] == BankOpen);
      sel_open = (bank_st[sdram_ba] == BankOpen);
      cmd_ok   = 1'b0;
      cmd_bad  = 1'b0;
      unique case (cmd)
         CmdAct:            if (sel_open) cmd_bad = 1'b1; else cmd_ok = 1'b1;
         CmdRead, CmdWrite: if (sel_open) cmd_ok = 1'b1; else cmd_bad = 1'b1;
         CmdAref:           if (any_open) cmd_bad = 1'b1; else cmd_ok = 1'b1;
         CmdLmr: begin
            if (any_open || !lmr_legal(sdram_addr[6:4], sdram_addr[2:0])) cmd_bad = 1'b1;
            else cmd_ok = 1'b1;
         end
         CmdPre, CmdBst:    cmd_ok = 1'b1;
         CmdNop:            cmd_ok = 1'b0;
      endcase
   end

   assign rw_ok   = cmd_ok && (cmd == CmdRead || cmd == CmdWrite);
   assign pre_hit = cmd_ok && cmd == CmdPre && (sdram_addr[10] || sdram_ba == burst_bank);
   // Writes yield to any accepted command; reads only to RD/WR/BST or a precharge of their bank.
   assign burst_stop = burst_wr ? cmd_ok : (rw_ok || (cmd_ok && cmd == CmdBst) || pre_hit);
   assign flush   = rw_ok && cmd == CmdWrite;

   always_comb begin
      issue      = 1'b0;
      issue_wr   = 1'b0;
      issue_bank = sdram_ba;
      issue_row  = bank_row[sdram_ba];
      issue_col  = sdram_addr[ColW-1:0];
      if (rw_ok) begin
         issue    = 1'b1;
         issue_wr = (cmd == CmdWrite);
      end else if (burst_left != 3'd0 && !burst_stop) begin
         issue      = 1'b1;
         issue_wr   = burst_wr;
         issue_bank = burst_bank;
         issue_row  = burst_row;
         issue_col  = wrap_col(burst_col0, burst_idx, burst_mask);
      end
   end

   assign full_addr  = {issue_bank, issue_row, issue_col};
   assign store_addr = full_addr[STORE_AW-1:0] ^ {{(STORE_AW-1){1'b0}}, full_addr[STORE_AW]};

   always_ff @(posedge clk_clk) begin
      if (sdram_cke && issue && !reset_reset) begin
         if (issue_wr) begin
            for (int b = 0; b < ByteW; b++)
               if (!sdram_dqm[b]) mem[store_addr][8*b +: 8] <= sdram_dq_in[8*b +: 8];
         end else begin
            ram_q <= mem[store_addr];
         end
      end
   end

   // CL3 beats enter one slot deeper; the dqm that gates a beat is the one two edges before it.
   assign ins_pos = cl_q[0];
   assign ins_oe  = cl_q[0] ? ~sdram_dqm : ~dqm_q;

   sdram_rd_pipe #(.DEPTH(ClMax - 1)) u_rd_pipe (
      .clk       (clk_clk),
      .reset     (reset_reset),
      .en        (sdram_cke),
      .flush     (flush),
      .ins_valid (rd_issue),
      .ins_pos   (ins_pos),
      .ins_data  (ram_q),
      .ins_oe    (ins_oe),
      .head      (pipe_head)
   );

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         for (int i = 0; i < NumBanks; i++) begin
            bank_st[i]  <= BankIdle;
            bank_row[i] <= '0;
         end
         cl_q         <= 2'(CL_DEFAULT);
         bl_mask_q    <= 3'd0;
         burst_wr     <= 1'b0;
         burst_left   <= 3'd0;
         burst_idx    <= 3'd0;
         burst_mask   <= 3'd0;
         burst_bank   <= '0;
         burst_row    <= '0;
         burst_col0   <= '0;
         rd_issue     <= 1'b0;
         dqm_q        <= 4'd0;
         cmd_err      <= 1'b0;
         refresh_cnt  <= 16'd0;
         sdram_dq_out <= 32'd0;
         sdram_dq_oe  <= 4'd0;
      end else if (sdram_cke) begin
         cmd_err  <= cmd_bad;
         dqm_q    <= sdram_dqm;
         rd_issue <= issue && !issue_wr;
         if (cmd_ok) begin
            case (cmd)
               CmdAct: begin
                  bank_st[sdram_ba]  <= BankOpen;
                  bank_row[sdram_ba] <= sdram_addr[RowW-1:0];
               end
               CmdPre: begin
                  for (int i = 0; i < NumBanks; i++)
                     if (sdram_addr[10] || sdram_ba == 2'(i)) bank_st[i] <= BankIdle;
               end
               CmdAref: refresh_cnt <= refresh_cnt + 16'd1;
               CmdLmr: begin
                  cl_q      <= sdram_addr[5:4];
                  bl_mask_q <= bl_mask(sdram_addr[1:0]);
               end
               default: ;
            endcase
         end
         if (rw_ok) begin
            burst_wr   <= (cmd == CmdWrite);
            burst_bank <= sdram_ba;
            burst_row  <= bank_row[sdram_ba];
            burst_col0 <= sdram_addr[ColW-1:0];
            burst_mask <= bl_mask_q;
            burst_left <= bl_mask_q;
            burst_idx  <= 3'd1;
         end else if (burst_stop) begin
            burst_left <= 3'd0;
         end else if (burst_left != 3'd0) begin
            burst_left <= burst_left - 3'd1;
            burst_idx  <= burst_idx + 3'd1;
         end
         if (flush) begin
            sdram_dq_oe <= 4'd0;
         end else begin
            sdram_dq_oe <= pipe_head.valid ? pipe_head.oe : 4'd0;
            if (pipe_head.valid) sdram_dq_out <= pipe_head.data;
         end
      end
   end

`ifdef SDRAM_TIMING_CHECK_EN
   logic [3:0] tim_cnt [NumBanks];
   logic       tim_viol;

   // One counter per bank serves both tRP (checked by ACTIVE) and tRCD (checked by READ/WRITE).
   assign tim_viol = cmd_ok && (cmd == CmdAct || cmd == CmdRead || cmd == CmdWrite) &&
                     tim_cnt[sdram_ba] != 4'd0;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         timing_err <= 1'b0;
         for (int i = 0; i < NumBanks; i++) tim_cnt[i] <= 4'd0;
      end else if (sdram_cke) begin
         if (tim_viol) timing_err <= 1'b1;
         for (int i = 0; i < NumBanks; i++) begin
            if (cmd_ok && cmd == CmdAct && sdram_ba == 2'(i))
               tim_cnt[i] <= 4'(T_RCD - 1);
            else if (cmd_ok && cmd == CmdPre && (sdram_addr[10] || sdram_ba == 2'(i)))
               tim_cnt[i] <= 4'(T_RP - 1);
            else if (tim_cnt[i] != 4'd0)
               tim_cnt[i] <= tim_cnt[i] - 4'd1;
         end
      end
   end
`else
   logic [31:0] unused_timing;
   assign unused_timing = T_RCD + T_RP;
   assign timing_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: mode, bursts, masks, interrupts, errors and timing flag.
module tb_sdram_device_model;

   localparam logic [2:0] C_LMR = 3'b000, C_AREF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
   localparam logic [2:0] C_WR  = 3'b100, C_RD   = 3'b101, C_NOP = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic        cs_n, ras_n, cas_n, we_n, cke;
   logic [3:0]  dqm;
   logic [31:0] dq_in, dq_out;
   logic [3:0]  dq_oe;
   logic        cmd_err, timing_err;
   logic [15:0] refresh_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   sdram_device_model dut (
      .clk_clk      (clk),
      .reset_reset  (reset),
      .sdram_addr   (addr),
      .sdram_ba     (ba),
      .sdram_cs_n   (cs_n),
      .sdram_ras_n  (ras_n),
      .sdram_cas_n  (cas_n),
      .sdram_we_n   (we_n),
      .sdram_cke    (cke),
      .sdram_dqm    (dqm),
      .sdram_dq_in  (dq_in),
      .sdram_dq_out (dq_out),
      .sdram_dq_oe  (dq_oe),
      .cmd_err      (cmd_err),
      .timing_err   (timing_err),
      .refresh_cnt  (refresh_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one command for one edge; return 1ns after the edge so outputs can be sampled.
   task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      {ras_n, cas_n, we_n} = c;
      cs_n  = 1'b0;
      ba    = b;
      addr  = a;
      dq_in = d;
      dqm   = m;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(C_NOP, 2'd0, 13'd0, 32'd0, 4'd0);
   endtask

   task automatic open_row(input logic [1:0] b, input logic [12:0] row);
      tick(C_ACT, b, row, 32'd0, 4'd0);
      idle();
      idle();
   endtask

   task automatic close_all();
      tick(C_PRE, 2'd0, 13'h400, 32'd0, 4'd0);
      idle();
      idle();
   endtask

   initial begin
      reset = 1'b1;
      cke   = 1'b1;
      cs_n  = 1'b1;
      {ras_n, cas_n, we_n} = C_NOP;
      ba = 2'd0; addr = 13'd0; dq_in = 32'd0; dqm = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_dq_out", dq_out, 32'd0);
      check("rst_dq_oe", 32'(dq_oe), 32'd0);
      check("rst_cmd_err", 32'(cmd_err), 32'd0);
      check("rst_timing_err", 32'(timing_err), 32'd0);
      check("rst_refresh", 32'(refresh_cnt), 32'd0);

      // CL3 BL4: write 1..4 at col 0, read back on edges +3..+6
      tick(C_LMR, 2'd0, 13'h032, 32'd0, 4'd0);
      open_row(2'd1, 13'd5);
      for (int k = 0; k < 4; k++) tick((k == 0) ? C_WR : C_NOP, 2'd1, 13'd0, 32'(k + 1), 4'd0);
      tick(C_RD, 2'd1, 13'd0, 32'd0, 4'd0);
      for (int k = 1; k <= 7; k++) begin
         idle();
         if (k >= 3 && k <= 6) begin
            check($sformatf("t1_data_%0d", k), dq_out, 32'(k - 2));
            check($sformatf("t1_oe_%0d", k), 32'(dq_oe), 32'hF);
         end else begin
            check($sformatf("t1_oe_idle_%0d", k), 32'(dq_oe), 32'd0);
         end
      end

      // Refresh only counts with every bank idle
      tick(C_AREF, 2'd0, 13'd0, 32'd0, 4'd0);
      check("aref_open_err", 32'(cmd_err), 32'd1);
      check("aref_open_cnt", 32'(refresh_cnt), 32'd0);
      close_all();
      tick(C_AREF, 2'd0, 13'd0, 32'd0, 4'd0);
      check("aref_cnt", 32'(refresh_cnt), 32'd1);
      check("aref_no_err", 32'(cmd_err), 32'd0);

      // Illegal burst code rejected, then CL2 BL4 with wrapped column order
      tick(C_LMR, 2'd0, 13'h034, 32'd0, 4'd0);
      check("lmr_bad_bl", 32'(cmd_err), 32'd1);
      tick(C_LMR, 2'd0, 13'h022, 32'd0, 4'd0);
      open_row(2'd1, 13'd5);
      for (int k = 0; k < 4; k++)
         tick((k == 0) ? C_WR : C_NOP, 2'd1, 13'd4, 32'h40 + 32'(k) * 32'h10, 4'd0);
      tick(C_RD, 2'd1, 13'd6, 32'd0, 4'd0);
      idle();
      check("t2_oe_early", 32'(dq_oe), 32'd0);
      idle(); check("t2_col6", dq_out, 32'h60);
      idle(); check("t2_col7", dq_out, 32'h70);
      idle(); check("t2_col4", dq_out, 32'h40);
      idle(); check("t2_col5", dq_out, 32'h50);
      check("t2_oe", 32'(dq_oe), 32'hF);
      idle(); check("t2_oe_end", 32'(dq_oe), 32'd0);

      // Byte-masked write merge, then read-side dqm masking of beat 0
      tick(C_WR, 2'd1, 13'd8, 32'h11223344, 4'd0);
      repeat (3) tick(C_NOP, 2'd0, 13'd0, 32'd0, 4'hF);
      tick(C_WR, 2'd1, 13'd8, 32'hAABBCCDD, 4'b0101);
      repeat (3) tick(C_NOP, 2'd0, 13'd0, 32'd0, 4'hF);
      tick(C_RD, 2'd1, 13'd8, 32'd0, 4'd0);
      idle();
      idle();
      check("t3_merge", dq_out, 32'hAA22CC44);
      repeat (4) idle();
      tick(C_RD, 2'd1, 13'd8, 32'd0, 4'b0010);
      idle();
      idle(); check("t3_rd_mask", 32'(dq_oe), 32'hD);
      idle(); check("t3_rd_nomask", 32'(dq_oe), 32'hF);
      repeat (4) idle();

      // READ to an idle bank
      tick(C_RD, 2'd0, 13'd0, 32'd0, 4'd0);
      check("t4_err", 32'(cmd_err), 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) check("t4_err_pulse", 32'(cmd_err), 32'd1);
         idle();
         check($sformatf("t4_oe_%0d", k), 32'(dq_oe), 32'd0);
         check($sformatf("t4_err_low_%0d", k), 32'(cmd_err), 32'd0);
      end

      // CL3 BL8 read, WRITE four edges later cancels every pending beat
      close_all();
      tick(C_LMR, 2'd0, 13'h033, 32'd0, 4'd0);
      open_row(2'd1, 13'd5);
      tick(C_RD, 2'd1, 13'd0, 32'd0, 4'd0);
      idle(); idle(); idle();
      check("t5_rd_beat0", dq_out, 32'd1);
      check("t5_rd_oe", 32'(dq_oe), 32'hF);
      tick(C_WR, 2'd1, 13'd16, 32'h100, 4'd0);
      check("t5_oe_wr_edge", 32'(dq_oe), 32'd0);
      for (int k = 1; k < 8; k++) begin
         tick(C_NOP, 2'd0, 13'd0, 32'h100 + 32'(k), 4'd0);
         check($sformatf("t5_oe_cancel_%0d", k), 32'(dq_oe), 32'd0);
      end
      idle();
      tick(C_RD, 2'd1, 13'd16, 32'd0, 4'd0);
      idle(); idle();
      for (int k = 0; k < 8; k++) begin
         idle();
         check($sformatf("t5_rb_%0d", k), dq_out, 32'h100 + 32'(k));
      end
      idle();

      // ACTIVE then READ one edge later
      close_all();
      repeat (3) idle();
      check("t6_pre_clean", 32'(timing_err), 32'd0);
      open_row(2'd2, 13'd0);
      repeat (2) idle();
      tick(C_ACT, 2'd3, 13'd0, 32'd0, 4'd0);
      tick(C_RD, 2'd3, 13'd0, 32'd0, 4'd0);
`ifdef SDRAM_TIMING_CHECK_EN
      check("t6_viol", 32'(timing_err), 32'd1);
      repeat (3) idle();
      check("t6_sticky", 32'(timing_err), 32'd1);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      check("t6_reset_clears", 32'(timing_err), 32'd0);
`else
      check("t6_no_check", 32'(timing_err), 32'd0);
      repeat (3) idle();
      check("t6_no_check_hold", 32'(timing_err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
